// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator (master) and its consumers (slave).
// The consumer owns the clock enable. Every other signal is produced by the generator.
interface vga_timing_gen_if;
    logic       ena;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic [7:0] frame;
    logic       frame_start;

    modport master (
        input  ena,
        output pix_x, pix_y, display_on, hsync, vsync, frame, frame_start
    );

    modport slave (
        output ena,
        input  pix_x, pix_y, display_on, hsync, vsync, frame, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line/frame counters and sync pulses.
// The sync outputs are registered one clock behind the counters to line up with a registered color stage.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VISIBLE    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEGIN = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEGIN = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [7:0] frame_cnt;
    logic       hsync_q;
    logic       vsync_q;

    logic       h_wrap;
    logic       v_wrap;
    logic       hsync_term;
    logic       vsync_term;

    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        hsync_term = !((h_cnt >= H_SYNC_BEGIN) && (h_cnt < H_SYNC_END));
        vsync_term = !((v_cnt >= V_SYNC_BEGIN) && (v_cnt < V_SYNC_END));
    end

    // NOTE: state registers use non-blocking assignments so every register samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else if (vga.ena) begin
            hsync_q <= hsync_term;
            vsync_q <= vsync_term;
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt     <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Position-derived flags are decoded straight from the counters, so they have zero latency.
    assign vga.pix_x       = h_cnt;
    assign vga.pix_y       = v_cnt;
    assign vga.display_on  = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    assign vga.frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame       = frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a full-size 640x480 instance and a tiny-raster instance run side by side.
// A reference model pushes expected outputs for each clock, and a negedge monitor pops them and compares.
module tb_vga_timing_gen;
    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } cfg_t;

    typedef struct packed {
        int   h;
        int   v;
        int   frame;
        logic hs_q;
        logic vs_q;
    } st_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] fr;
        logic       fs;
    } obs_t;

    localparam cfg_t C_D = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};
    localparam cfg_t C_S = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 4, vf: 1, vs: 2, vb: 1};
    localparam int   S_HTOT = 15;
    localparam int   S_VTOT = 8;
    localparam st_t  RST_ST = '{h: 0, v: 0, frame: 0, hs_q: 1'b1, vs_q: 1'b1};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ena   = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    st_t  m_d = RST_ST;
    st_t  m_s = RST_ST;
    obs_t q_d[$];
    obs_t q_s[$];
    obs_t act_d, act_s, exp_d, exp_s;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s ();
    assign if_d.ena = ena;
    assign if_s.ena = ena;

    vga_timing_gen dut_d (.clk(clk), .reset(reset), .vga(if_d));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (.clk(clk), .reset(reset), .vga(if_s));

    always #5 clk = ~clk;

    assign act_d = {if_d.pix_x, if_d.pix_y, if_d.display_on, if_d.hsync, if_d.vsync, if_d.frame, if_d.frame_start};
    assign act_s = {if_s.pix_x, if_s.pix_y, if_s.display_on, if_s.hsync, if_s.vsync, if_s.frame, if_s.frame_start};

    function automatic st_t step(st_t s, cfg_t c);
        st_t n = s;
        int htot = c.ha + c.hf + c.hs + c.hb;
        int vtot = c.va + c.vf + c.vs + c.vb;
        n.hs_q = !(s.h >= c.ha + c.hf && s.h < c.ha + c.hf + c.hs);
        n.vs_q = !(s.v >= c.va + c.vf && s.v < c.va + c.vf + c.vs);
        if (s.h == htot - 1) begin
            n.h = 0;
            if (s.v == vtot - 1) begin
                n.v     = 0;
                n.frame = (s.frame + 1) % 256;
            end else begin
                n.v = s.v + 1;
            end
        end else begin
            n.h = s.h + 1;
        end
        return n;
    endfunction

    function automatic obs_t outs(st_t s, cfg_t c);
        obs_t o;
        o.x  = 10'(s.h);
        o.y  = 10'(s.v);
        o.de = (s.h < c.ha) && (s.v < c.va);
        o.hs = s.hs_q;
        o.vs = s.vs_q;
        o.fr = 8'(s.frame);
        o.fs = (s.h == 0) && (s.v == 0);
        return o;
    endfunction

    // One clock of stimulus: advance the model with the current inputs, queue the expectation, take the edge.
    task automatic tick();
        if (reset) begin
            m_d = RST_ST;
            m_s = RST_ST;
        end else if (ena) begin
            m_d = step(m_d, C_D);
            m_s = step(m_s, C_S);
        end
        q_d.push_back(outs(m_d, C_D));
        q_s.push_back(outs(m_s, C_S));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q_d.size() > 0) begin
            exp_d = q_d.pop_front();
            n_total++;
            if (act_d !== exp_d)
                $display("FAIL sb_full t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b fr=%0d fs=%b want x=%0d y=%0d de=%b hs=%b vs=%b fr=%0d fs=%b",
                         $time, act_d.x, act_d.y, act_d.de, act_d.hs, act_d.vs, act_d.fr, act_d.fs,
                         exp_d.x, exp_d.y, exp_d.de, exp_d.hs, exp_d.vs, exp_d.fr, exp_d.fs);
            else
                n_pass++;
        end
        if (q_s.size() > 0) begin
            exp_s = q_s.pop_front();
            n_total++;
            if (act_s !== exp_s)
                $display("FAIL sb_small t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b fr=%0d fs=%b want x=%0d y=%0d de=%b hs=%b vs=%b fr=%0d fs=%b",
                         $time, act_s.x, act_s.y, act_s.de, act_s.hs, act_s.vs, act_s.fr, act_s.fs,
                         exp_s.x, exp_s.y, exp_s.de, exp_s.hs, exp_s.vs, exp_s.fr, exp_s.fs);
            else
                n_pass++;
        end
    end

    task automatic wait_small(input int x, input int y, input int budget, input string name);
        int k = 0;
        while (!(if_s.pix_x == 10'(x) && if_s.pix_y == 10'(y)) && k < budget) begin
            tick();
            k++;
        end
        n_total++;
        if (k >= budget)
            $display("FAIL %s timeout got x=%0d y=%0d want x=%0d y=%0d", name, if_s.pix_x, if_s.pix_y, x, y);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        obs_t want;
        #1 reset = 1'b1;
        #1;
        want = outs(RST_ST, C_D);
        n_total++;
        if (act_d !== want) $display("FAIL reset_full got %h want %h", act_d, want);
        else n_pass++;
        want = outs(RST_ST, C_S);
        n_total++;
        if (act_s !== want) $display("FAIL reset_small got %h want %h", act_s, want);
        else n_pass++;
        ena = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_hold_at_origin();
        reset = 1'b0;
        ena   = 1'b0;
        repeat (4) tick();
        n_total++;
        if (if_s.frame_start !== 1'b1 || if_s.pix_x !== 10'd0)
            $display("FAIL hold_origin got fs=%b x=%0d want fs=1 x=0", if_s.frame_start, if_s.pix_x);
        else
            n_pass++;
        ena = 1'b1;
        tick();
        n_total++;
        if (if_d.pix_x !== 10'd1) $display("FAIL first_count got x=%0d want x=1", if_d.pix_x);
        else n_pass++;
    endtask

    task automatic test_hsync_line();
        int k = 0;
        int lows = 0;
        int first_low = -1;
        int first_high = -1;
        logic prev;
        while (!(if_d.pix_x == 10'd0 && if_d.pix_y == 10'd1) && k < 2000) begin
            tick();
            k++;
        end
        n_total++;
        if (k >= 2000) $display("FAIL hsync_sync timeout got y=%0d want y=1", if_d.pix_y);
        else n_pass++;
        prev = if_d.hsync;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!if_d.hsync) lows++;
            if (prev && !if_d.hsync && first_low < 0) first_low = int'(if_d.pix_x);
            if (!prev && if_d.hsync && first_high < 0) first_high = int'(if_d.pix_x);
            prev = if_d.hsync;
        end
        n_total++;
        if (lows !== 96) $display("FAIL hsync_width got %0d want 96", lows);
        else n_pass++;
        n_total++;
        if (first_low !== 657) $display("FAIL hsync_fall got x=%0d want x=657", first_low);
        else n_pass++;
        n_total++;
        if (first_high !== 753) $display("FAIL hsync_rise got x=%0d want x=753", first_high);
        else n_pass++;
    endtask

    task automatic test_vsync_frame();
        int lows = 0;
        int low_x = -1;
        int low_y = -1;
        logic prev;
        wait_small(0, 0, 200, "vsync_sync");
        prev = if_s.vsync;
        for (int i = 0; i < S_HTOT * S_VTOT; i++) begin
            tick();
            if (!if_s.vsync) lows++;
            if (prev && !if_s.vsync && low_x < 0) begin
                low_x = int'(if_s.pix_x);
                low_y = int'(if_s.pix_y);
            end
            prev = if_s.vsync;
        end
        n_total++;
        if (lows !== 2 * S_HTOT) $display("FAIL vsync_width got %0d want %0d", lows, 2 * S_HTOT);
        else n_pass++;
        n_total++;
        if (low_x !== 1 || low_y !== 5) $display("FAIL vsync_fall got x=%0d y=%0d want x=1 y=5", low_x, low_y);
        else n_pass++;
    endtask

    task automatic test_enable_freeze();
        wait_small(5, 3, 200, "freeze_sync");
        ena = 1'b0;
        repeat (5) tick();
        n_total++;
        if (if_s.pix_x !== 10'd5 || if_s.pix_y !== 10'd3)
            $display("FAIL freeze_hold got x=%0d y=%0d want x=5 y=3", if_s.pix_x, if_s.pix_y);
        else
            n_pass++;
        ena = 1'b1;
        tick();
        n_total++;
        if (if_s.pix_x !== 10'd6) $display("FAIL freeze_resume got x=%0d want x=6", if_s.pix_x);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        wait_small(7, 5, 400, "areset_sync");
        @(negedge clk);
        #1 reset = 1'b1;
        m_d = RST_ST;
        m_s = RST_ST;
        #1;
        n_total++;
        if (act_s !== outs(RST_ST, C_S)) $display("FAIL areset_small got %h want %h", act_s, outs(RST_ST, C_S));
        else n_pass++;
        n_total++;
        if (act_d !== outs(RST_ST, C_D)) $display("FAIL areset_full got %h want %h", act_d, outs(RST_ST, C_D));
        else n_pass++;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_total++;
        if (if_s.pix_x !== 10'd1 || if_s.frame !== 8'd0)
            $display("FAIL areset_restart got x=%0d fr=%0d want x=1 fr=0", if_s.pix_x, if_s.frame);
        else
            n_pass++;
    endtask

    task automatic test_frame_rollover();
        int pulses = 0;
        for (int i = 0; i < 256 * S_HTOT * S_VTOT; i++) begin
            tick();
            if (if_s.frame_start) begin
                pulses++;
                n_total++;
                if (if_s.frame !== 8'(pulses % 256))
                    $display("FAIL frame_step got %0d want %0d", if_s.frame, pulses % 256);
                else
                    n_pass++;
            end
        end
        n_total++;
        if (pulses !== 256) $display("FAIL frame_pulses got %0d want 256", pulses);
        else n_pass++;
        n_total++;
        if (if_s.frame !== 8'd0) $display("FAIL frame_wrap got %0d want 0", if_s.frame);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hold_at_origin();
        test_hsync_line();
        test_vsync_frame();
        test_enable_freeze();
        test_async_reset();
        test_frame_rollover();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixel clocks.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixel clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixel clocks.
REQ-005 Parameter V_ACTIVE / V_FRONT / V_SYNC / V_BACK, defaults 480 / 10 / 2 / 33, vertical equivalents in lines.
REQ-006 clk  input  1  pixel clock (25.175 MHz nominal); the block uses one clock.
REQ-007 reset  input  1  reset; asynchronous and active-high.
REQ-008 ena  input  1  clock enable; when low, all registers hold.
REQ-009 pix_x  output  10  current horizontal counter, 0..H_TOTAL-1.
REQ-010 pix_y  output  10  current vertical counter, 0..V_TOTAL-1.
REQ-011 display_on  output  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE.
REQ-012 hsync  output  1  active-low horizontal sync, delayed one clock to align with the registered color stage.
REQ-013 vsync  output  1  active-low vertical sync, delayed one clock to align with the registered color stage.
REQ-014 frame  output  8  frame counter for dither and animation in the downstream flag stages.
REQ-015 frame_start  output  1  one-clock pulse while pix_x==0 and pix_y==0.

Function
REQ-016 H_TOTAL SHALL equal H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal the vertical sum (525).
REQ-017 On each enabled clock, the h counter SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-018 The v counter SHALL increment only on the clock where h wraps; at V_TOTAL-1 with h wrap it SHALL wrap to 0.
REQ-019 frame SHALL increment by 1, modulo 256, on the clock where both h and v wrap.
REQ-020 frame SHALL roll over 255 -> 0 with no flag and no stall.
REQ-021 pix_x and pix_y SHALL be the counter registers directly, with zero latency.
REQ-022 display_on and frame_start SHALL be combinational from the counters, with zero latency.
REQ-023 The internal hsync term SHALL be low when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751).
REQ-024 The internal vsync term SHALL be low when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC (490..491).
REQ-025 The hsync and vsync outputs SHALL equal the internal terms registered once, i.e. one clock later than the pix_x/pix_y that produced them.
REQ-026 The hsync and vsync registers SHALL update only when ena is high.
REQ-027 With ena low, every output SHALL remain constant, including frame_start if it is already high.
REQ-028 Counter arithmetic SHALL be unsigned 10-bit; no counter SHALL ever exceed its TOTAL-1.

Reset
REQ-029 Asserting reset SHALL immediately force h=0, v=0, frame=0, hsync=1 and vsync=1, regardless of clk or ena.
REQ-030 During reset, display_on SHALL be 1 and frame_start SHALL be 1, as combinational consequences of h=0 and v=0.
REQ-031 After reset deasserts, counting SHALL begin on the first enabled rising edge, giving pix_x=1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL start at 0,0 with frame=0.

Verification
REQ-033 Free-run from reset with ena=1 -> pix_x=639 display_on=1; pix_x=640 display_on=0; pix_x=799 -> 0 with pix_y incremented.
REQ-034 Check hsync across a line -> hsync low for exactly 96 clocks, first low on the clock after pix_x=656, high again on the clock after pix_x=752.
REQ-035 Check vsync across a frame -> vsync low for exactly 2 x 800 clocks, beginning the clock after pix_x=0 pix_y=490.
REQ-036 Run 256 frames (256 x 420000 clocks) -> frame steps 0,1,...,255,0; frame_start pulses once per 420000 clocks.
REQ-037 Toggle ena low for 5 clocks at pix_x=100 pix_y=200 -> all outputs frozen; pix_x resumes at 101.
REQ-038 Assert reset asynchronously between clk edges at pix_y=300 -> outputs go to 0,0, frame=0, hsync=vsync=1 before the next edge.
